region_offset_ctrl: RTL

//  Clocked, parametrised controller for the position of the drawable character region inside the VGA active area.

---
 rtl/vga_region_pkg.sv | 17 +
 rtl/region_axis.sv | 129 ++++++++++++
 rtl/region_offset_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/vga_region_pkg.sv
// Shared constants for the VGA drawable-region controller: screen defaults,
// direction bit positions in the request vector and the charSize decode.
package vga_region_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   function automatic logic [3:0] size_to_scale(input logic [2:0] char_size);
      return 4'(char_size) + 4'd1;
   endfunction

endpackage

// File: rtl/region_axis.sv
// One axis of the region position: press edge detect, hold-to-repeat counter,
// start register (wrap or clamp) and the registered end/wrap outputs.
module region_axis #(
   parameter int ACTIVE        = 640,
   parameter int BASE          = 32,
   parameter int STEP_MODE     = 0,
   parameter int STEP          = 8,
   parameter int WRAP_EN       = 1,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 1,
   localparam int AW = $clog2(ACTIVE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    scale,
   input  logic          size_chg,
   input  logic          flag_dec,
   input  logic          flag_inc,
   output logic [AW-1:0] pos_start,
   output logic [AW-1:0] pos_end,
   output logic          wrap,
   output logic          moved
);

   localparam int XW = AW + 2;
   localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 2);
   localparam logic [XW-1:0] ACT = XW'(ACTIVE);
   localparam logic REP_EN = (REPEAT_DELAY > 0);
   localparam logic [CW-1:0] CNT_FIRST = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] CNT_AGAIN = CW'(REPEAT_DELAY + REPEAT_PERIOD);

   function automatic logic [XW-1:0] end_of(input logic [XW-1:0] s,
                                             input logic [XW-1:0] d);
      logic [XW-1:0] e;
      e = s + d - XW'(1);
      if (e >= ACT) e = e - ACT;
      return e;
   endfunction

   logic          flag_dec_q, flag_inc_q;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [AW-1:0] start_q, start_d, end_q, end_d;
   logic [AW-1:0] rst_start_d, rst_end_d;
   logic          wrap_q, wrap_d, moved_q, moved_d;

   logic [XW-1:0] dim, step, max_start, base, sum, nxt, end_x;
   logic          press_dec, press_inc, held_dec, held_inc, rep_fire;
   logic          do_dec, do_inc;

   always_comb begin
      dim       = XW'(BASE) * XW'(scale);
      step      = (STEP_MODE != 0) ? XW'(STEP) : dim;
      max_start = ACT - dim;

      rst_start_d = AW'((ACT - dim) >> 1);
      rst_end_d   = AW'(end_of(XW'(rst_start_d), dim));

      // Opposite requests cancel: neither a press nor a hold on this axis.
      press_dec = flag_dec & ~flag_dec_q & ~flag_inc;
      press_inc = flag_inc & ~flag_inc_q & ~flag_dec;
      held_dec  = flag_dec & flag_dec_q & ~flag_inc;
      held_inc  = flag_inc & flag_inc_q & ~flag_dec;

      cnt_inc  = cnt_q + CW'(1);
      cnt_d    = '0;
      rep_fire = 1'b0;
      if (REP_EN && (held_dec || held_inc)) begin
         if (cnt_inc == CNT_FIRST) begin
            rep_fire = 1'b1;
            cnt_d    = cnt_inc;
         end else if (cnt_inc == CNT_AGAIN) begin
            rep_fire = 1'b1;
            cnt_d    = CNT_FIRST;
         end else begin
            cnt_d    = cnt_inc;
         end
      end

      do_dec = press_dec | (rep_fire & held_dec);
      do_inc = press_inc | (rep_fire & held_inc);

      // A size change in clamp mode can push the region past the edge; pull it back.
      base = XW'(start_q);
      if ((WRAP_EN == 0) && size_chg && (base > max_start)) base = max_start;

      sum = base + step;
      nxt = base;
      if (do_dec) begin
         if (base >= step)      nxt = base - step;
         else if (WRAP_EN != 0) nxt = base + ACT - step;
         else                   nxt = '0;
      end else if (do_inc) begin
         if (WRAP_EN != 0) nxt = (sum < ACT) ? sum : sum - ACT;
         else              nxt = (sum > max_start) ? max_start : sum;
      end

      end_x   = end_of(nxt, dim);
      start_d = AW'(nxt);
      end_d   = AW'(end_x);
      wrap_d  = (end_x < nxt);
      moved_d = (start_d != start_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_dec_q <= 1'b0;
         flag_inc_q <= 1'b0;
         cnt_q      <= '0;
         start_q    <= rst_start_d;
         end_q      <= rst_end_d;
         wrap_q     <= 1'b0;
         moved_q    <= 1'b0;
      end else begin
         flag_dec_q <= flag_dec;
         flag_inc_q <= flag_inc;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         end_q      <= end_d;
         wrap_q     <= wrap_d;
         moved_q    <= moved_d;
      end
   end

   assign pos_start = start_q;
   assign pos_end   = end_q;
   assign wrap      = wrap_q;
   assign moved     = moved_q;

endmodule

// File: rtl/region_offset_ctrl.sv
// Position of the drawable character region inside the VGA active area;
// two independent axis controllers sharing the registered char size.
module region_offset_ctrl
   import vga_region_pkg::*;
#(
   parameter int H_ACTIVE      = H_ACTIVE_DEF,
   parameter int V_ACTIVE      = V_ACTIVE_DEF,
   parameter int BASE_W        = 32,
   parameter int BASE_H        = 32,
   parameter int STEP_MODE     = 0,
   parameter int STEP_PX       = 8,
   parameter int STEP_LN       = 8,
   parameter int WRAP_EN       = 1,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 1,
   localparam int HW = $clog2(H_ACTIVE),
   localparam int VW = $clog2(V_ACTIVE)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    charSize,
   input  logic [3:0]    OffsetFlag,
   output logic [HW-1:0] posHorStart,
   output logic [HW-1:0] posHorEnd,
   output logic [VW-1:0] posVerStart,
   output logic [VW-1:0] posVerEnd,
   output logic          horWrap,
   output logic          verWrap,
   output logic          moved
);

   logic [2:0] char_size_q, char_size_d;
   logic [3:0] scale;
   logic       size_chg;
   logic       hor_moved, ver_moved;

   always_comb begin
      char_size_d = charSize;
      scale       = size_to_scale(charSize);
      size_chg    = (charSize != char_size_q);
   end

   always_ff @(posedge clk) begin
      if (reset) char_size_q <= charSize;
      else       char_size_q <= char_size_d;
   end

   region_axis #(
      .ACTIVE        (H_ACTIVE),
      .BASE          (BASE_W),
      .STEP_MODE     (STEP_MODE),
      .STEP          (STEP_PX),
      .WRAP_EN       (WRAP_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_hor (
      .clk       (clk),
      .reset     (reset),
      .scale     (scale),
      .size_chg  (size_chg),
      .flag_dec  (OffsetFlag[DIR_LEFT]),
      .flag_inc  (OffsetFlag[DIR_RIGHT]),
      .pos_start (posHorStart),
      .pos_end   (posHorEnd),
      .wrap      (horWrap),
      .moved     (hor_moved)
   );

   region_axis #(
      .ACTIVE        (V_ACTIVE),
      .BASE          (BASE_H),
      .STEP_MODE     (STEP_MODE),
      .STEP          (STEP_LN),
      .WRAP_EN       (WRAP_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_ver (
      .clk       (clk),
      .reset     (reset),
      .scale     (scale),
      .size_chg  (size_chg),
      .flag_dec  (OffsetFlag[DIR_UP]),
      .flag_inc  (OffsetFlag[DIR_DOWN]),
      .pos_start (posVerStart),
      .pos_end   (posVerEnd),
      .wrap      (verWrap),
      .moved     (ver_moved)
   );

   assign moved = hor_moved | ver_moved;

endmodule
